// File: rtl/fifo_wm_pkg.sv
// Shared sizing helpers for the watermark FIFO (fifo_wm) and its pointer sub-module.
package fifo_wm_pkg;

  function automatic int cntW(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Never return zero so that a pointer always has at least one index bit.
  function automatic int ptrW(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_wm_ptr.sv
// Wrap-bit FIFO pointer: index bits count 0..DEPTH-1, MSb toggles on each wrap,
// which also makes non-power-of-2 depths work.
module fifo_wm_ptr
  import fifo_wm_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = ptrW(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [PTR_W:0]   o_ptr
);

  localparam logic [PTR_W-1:0] MAX_IDX = PTR_W'(DEPTH - 1);

  logic [PTR_W:0] ptr_q;
  logic [PTR_W:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      if (ptr_q[PTR_W-1:0] == MAX_IDX) begin
        ptr_d = {~ptr_q[PTR_W], {PTR_W{1'b0}}};
      end else begin
        ptr_d = ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else if (i_cg) begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/fifo_wm.sv
// Synchronous FIFO with runtime almost-full/empty watermarks and sticky error flags.
// Optional high-water register enabled by defining FIFO_WM_HIGHWATER_EN.
module fifo_wm
  import fifo_wm_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int DEPTH         = 8,
  parameter  int FLOPS_NOT_MEM = 0,
  localparam int CNT_W         = cntW(DEPTH),
  localparam int PTR_W         = ptrW(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic                   i_flush,
  input  logic                   i_clrErr,
  input  logic [CNT_W-1:0]       i_afThresh,
  input  logic [CNT_W-1:0]       i_aeThresh,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [CNT_W-1:0]       o_nEntries,
  output logic                   o_almostFull,
  output logic                   o_almostEmpty,
  output logic                   o_overflow,
  output logic                   o_underflow,
  output logic [CNT_W-1:0]       o_highWater,
  output logic [DEPTH*WIDTH-1:0] o_entries
);

  // Handshake: a word moves on a cycle where valid and ready are both high
  // (push: i_valid && o_ready, pop: o_valid && i_ready) with i_cg high and no
  // flush; valid never waits on ready, and a request facing a low partner is
  // not a transfer, it raises the matching sticky error flag instead.

  logic [PTR_W:0]   wptr;
  logic [PTR_W:0]   rptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty   = (wptr == rptr);
  assign full    = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign o_ready = ~full;
  assign o_valid = ~empty;
  assign push    = i_valid & o_ready & ~i_flush;
  assign pop     = i_ready & o_valid & ~i_flush;

  fifo_wm_ptr #(.DEPTH(DEPTH)) u_wptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cg  (i_cg),
    .i_clr (i_flush),
    .i_inc (push),
    .o_ptr (wptr)
  );

  fifo_wm_ptr #(.DEPTH(DEPTH)) u_rptr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_cg  (i_cg),
    .i_clr (i_flush),
    .i_inc (pop),
    .o_ptr (rptr)
  );

  // Error flags: a new event in the same cycle as a clear keeps the flag set.
  always_comb begin
    cnt_d = cnt_q;
    if (i_flush) begin
      cnt_d = '0;
    end else if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    ovf_d = (i_valid & ~o_ready) | (ovf_q & ~(i_clrErr | i_flush));
    unf_d = (i_ready & ~o_valid) | (unf_q & ~(i_clrErr | i_flush));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (i_cg) begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && i_cg && push) begin
      mem_q[wptr[PTR_W-1:0]] <= i_data;
    end
  end

  assign o_data        = mem_q[rptr[PTR_W-1:0]];
  assign o_nEntries    = cnt_q;
  assign o_almostFull  = (cnt_q >= i_afThresh);
  assign o_almostEmpty = (cnt_q <= i_aeThresh);
  assign o_overflow    = ovf_q;
  assign o_underflow   = unf_q;

  generate
    if (FLOPS_NOT_MEM != 0) begin : g_entries
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign o_entries[gi*WIDTH +: WIDTH] = mem_q[gi];
      end
    end else begin : g_no_entries
      assign o_entries = '0;
    end
  endgenerate

`ifdef FIFO_WM_HIGHWATER_EN
  logic [CNT_W-1:0] hw_q, hw_d;

  always_comb begin
    hw_d = (cnt_q > hw_q) ? cnt_q : hw_q;
    if (i_flush || i_clrErr) begin
      hw_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hw_q <= '0;
    end else if (i_cg) begin
      hw_q <= hw_d;
    end
  end

  assign o_highWater = hw_q;
`else
  assign o_highWater = '0;
`endif

endmodule

// File: tb/tb_fifo_wm.sv
// Directed self-checking bench for fifo_wm at DEPTH=6 with flop storage exposed.
module tb_fifo_wm;

  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int CNT_W = 3;
`ifdef FIFO_WM_HIGHWATER_EN
  localparam int HW_EXP = 5;
`else
  localparam int HW_EXP = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cg;
  logic                   flush;
  logic                   clr_err;
  logic [CNT_W-1:0]       af_th;
  logic [CNT_W-1:0]       ae_th;
  logic [WIDTH-1:0]       din;
  logic                   din_valid;
  logic                   din_ready;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic                   dout_ready;
  logic [CNT_W-1:0]       n_entries;
  logic                   almost_full;
  logic                   almost_empty;
  logic                   overflow;
  logic                   underflow;
  logic [CNT_W-1:0]       high_water;
  logic [DEPTH*WIDTH-1:0] entries;

  int n_vec  = 0;
  int n_miss = 0;
  logic [WIDTH-1:0] exp_q[$];

  fifo_wm #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FLOPS_NOT_MEM(1)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cg          (cg),
    .i_flush       (flush),
    .i_clrErr      (clr_err),
    .i_afThresh    (af_th),
    .i_aeThresh    (ae_th),
    .i_data        (din),
    .i_valid       (din_valid),
    .o_ready       (din_ready),
    .o_data        (dout),
    .o_valid       (dout_valid),
    .i_ready       (dout_ready),
    .o_nEntries    (n_entries),
    .o_almostFull  (almost_full),
    .o_almostEmpty (almost_empty),
    .o_overflow    (overflow),
    .o_underflow   (underflow),
    .o_highWater   (high_water),
    .o_entries     (entries)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int n, input logic [WIDTH-1:0] base);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din       = base + WIDTH'(i);
      tick();
      exp_q.push_back(base + WIDTH'(i));
    end
    din_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    logic [WIDTH-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("drain_data", dout, e);
      dout_ready = 1'b1;
      tick();
    end
    dout_ready = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] e;
    rst = 1'b1; cg = 1'b1; flush = 1'b0; clr_err = 1'b0;
    af_th = 3'd4; ae_th = 3'd1;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_valid", dout_valid, 0);
    check("rst_ready", din_ready, 1);
    check("rst_count", n_entries, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_af", almost_full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_hw", high_water, 0);

    // Fill to full while watching both watermarks.
    for (int i = 0; i < DEPTH; i++) begin
      din_valid = 1'b1;
      din       = 8'h10 + 8'(i);
      tick();
      exp_q.push_back(8'h10 + 8'(i));
      check("fill_count", n_entries, i + 1);
      check("fill_af", almost_full, (i + 1) >= 4);
      check("fill_ae", almost_empty, (i + 1) <= 1);
    end
    din_valid = 1'b0;
    check("full_ready", din_ready, 0);
    check("full_valid", dout_valid, 1);
    check("full_entries", entries, 48'h151413121110);
    drain(DEPTH);
    check("empty_valid", dout_valid, 0);
    check("empty_count", n_entries, 0);

    // Flush drops the same-cycle push and suppresses its write.
    rst = 1'b1; tick(); rst = 1'b0;
    fill(3, 8'h21);
    flush = 1'b1; din_valid = 1'b1; din = 8'hEE;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    exp_q.delete();
    check("flush_count", n_entries, 0);
    check("flush_valid", dout_valid, 0);
    check("flush_slot3", entries[31:24], 8'h13);
    fill(1, 8'h77);
    drain(1);

    // High-water mark.
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    fill(5, 8'h30);
    drain(5);
    tick();
    check("hw_peak", high_water, HW_EXP);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("hw_clear", high_water, 0);

    // Continuous push+pop at occupancy 1 wraps both pointers.
    fill(1, 8'h40);
    for (int i = 0; i < 20; i++) begin
      e = exp_q.pop_front();
      check("wrap_data", dout, e);
      din_valid = 1'b1; dout_ready = 1'b1; din = 8'h41 + 8'(i);
      tick();
      exp_q.push_back(8'h41 + 8'(i));
      check("wrap_count", n_entries, 1);
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    drain(1);

    // Overflow, and full with push+pop executes only the pop.
    fill(DEPTH, 8'h50);
    din_valid = 1'b1; din = 8'hAA;
    tick();
    din_valid = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_count", n_entries, 6);
    tick();
    check("ovf_sticky", overflow, 1);
    e = exp_q.pop_front();
    check("fullpp_data", dout, e);
    din_valid = 1'b1; dout_ready = 1'b1; din = 8'hBB;
    tick();
    din_valid = 1'b0; dout_ready = 1'b0;
    check("fullpp_count", n_entries, 5);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_clear", overflow, 0);
    fill(1, 8'h56);

    // Clock gate low freezes everything, including flush and clear.
    din_valid = 1'b1; tick(); din_valid = 1'b0;
    cg = 1'b0; din_valid = 1'b1; dout_ready = 1'b1; clr_err = 1'b1; flush = 1'b1;
    tick(); tick(); tick();
    cg = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; clr_err = 1'b0; flush = 1'b0;
    check("cg_count", n_entries, 6);
    check("cg_ovf", overflow, 1);
    check("cg_data", dout, 8'h51);
    check("cg_ready", din_ready, 0);
    drain(DEPTH);

    // Underflow, and set-wins against a same-cycle clear.
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    check("unf_set", underflow, 1);
    check("unf_count", n_entries, 0);
    dout_ready = 1'b1; clr_err = 1'b1; tick(); dout_ready = 1'b0;
    check("unf_set_wins", underflow, 1);
    tick(); clr_err = 1'b0;
    check("unf_clear", underflow, 0);
    check("ovf_after_clr", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
